// File: rtl/mem_arbiter.sv
// Two-port (IF / LS) arbiter and sequencer for a single-ported memory.
// One transaction in flight, bounded LS-over-IF starvation, per-transaction timeout.
module mem_arbiter #(
    parameter int XLEN          = 64,
    parameter int TIMEOUT       = 16,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_req_ready,
    output logic            if_resp_valid,
    input  logic            ls_req_valid,
    input  logic            ls_req_rw,
    input  logic [XLEN-1:0] ls_req_addr,
    input  logic [XLEN-1:0] ls_req_wdata,
    output logic            ls_req_ready,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_valid,
    output logic            mem_rw,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [1:0]      fsm_state
);
    // Handshake: a request is held until its one-cycle ready pulse; mem_valid
    // is held with stable mem_* until mem_ack; each accepted request gets
    // exactly one one-cycle resp_valid on its own port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] streak;
    logic          gnt_ls;
    logic          pick_ls;

    // LS wins ties until it has starved a waiting IF MAX_LS_STREAK times in a row.
    assign pick_ls   = ls_req_valid && !(if_req_valid && (streak == STREAK_MAX));
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            streak        <= '0;
            gnt_ls        <= 1'b0;
            if_req_ready  <= 1'b0;
            ls_req_ready  <= 1'b0;
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rw        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            if_req_ready  <= 1'b0;
            ls_req_ready  <= 1'b0;
            if_resp_valid <= 1'b0;
            ls_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_valid || ls_req_valid) begin
                        gnt_ls    <= pick_ls;
                        tmo_cnt   <= '0;
                        mem_valid <= 1'b1;
                        state     <= BUSY;
                        if (pick_ls) begin
                            mem_rw       <= ls_req_rw;
                            mem_addr     <= ls_req_addr;
                            mem_wdata    <= ls_req_wdata;
                            ls_req_ready <= 1'b1;
                            if (!if_req_valid)
                                streak <= '0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + SW'(1);
                        end else begin
                            mem_rw       <= 1'b0;
                            mem_addr     <= if_req_addr;
                            mem_wdata    <= '0;
                            if_req_ready <= 1'b1;
                            streak       <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        resp_rdata    <= mem_rdata;
                        resp_err      <= 1'b0;
                        mem_valid     <= 1'b0;
                        if_resp_valid <= !gnt_ls;
                        ls_resp_valid <= gnt_ls;
                        state         <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_rdata    <= '0;
                        resp_err      <= 1'b1;
                        mem_valid     <= 1'b0;
                        if_resp_valid <= !gnt_ls;
                        ls_resp_valid <= gnt_ls;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency, arbitration/starvation,
// write path, timeout, mid-transaction reset and spurious acks.
module tb_mem_arbiter;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req_valid;
    logic [XLEN-1:0] if_req_addr;
    logic            if_req_ready;
    logic            if_resp_valid;
    logic            ls_req_valid;
    logic            ls_req_rw;
    logic [XLEN-1:0] ls_req_addr;
    logic [XLEN-1:0] ls_req_wdata;
    logic            ls_req_ready;
    logic            ls_resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            mem_valid;
    logic            mem_rw;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic [1:0]      fsm_state;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] last_rdata;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(16), .MAX_LS_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
        .ls_req_valid(ls_req_valid), .ls_req_rw(ls_req_rw),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_ready(ls_req_ready), .ls_resp_valid(ls_resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Each call advances one cycle; values are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_b({tag, "_mem_valid"}, mem_valid, 1'b0);
        chk_b({tag, "_if_ready"}, if_req_ready, 1'b0);
        chk_b({tag, "_ls_ready"}, ls_req_ready, 1'b0);
        chk_b({tag, "_if_resp"}, if_resp_valid, 1'b0);
        chk_b({tag, "_ls_resp"}, ls_resp_valid, 1'b0);
        chk_w({tag, "_rdata"}, resp_rdata, 64'd0);
        chk_b({tag, "_err"}, resp_err, 1'b0);
        chk_w({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk_w({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk_b({tag, "_mem_rw"}, mem_rw, 1'b0);
        chk_w({tag, "_state"}, 64'(fsm_state), 64'd0);
    endtask

    // Called at the start of an IDLE cycle with request inputs already set;
    // ack latency 1. Returns at the start of the following IDLE cycle.
    task automatic txn(input string tag, input logic exp_ls);
        logic [XLEN-1:0] rd;
        tick();
        chk_b({tag, "_ls_ready"}, ls_req_ready, exp_ls);
        chk_b({tag, "_if_ready"}, if_req_ready, !exp_ls);
        chk_b({tag, "_mem_rw"}, mem_rw, exp_ls ? ls_req_rw : 1'b0);
        chk_w({tag, "_mem_addr"}, mem_addr, exp_ls ? ls_req_addr : if_req_addr);
        chk_w({tag, "_mem_wdata"}, mem_wdata, exp_ls ? ls_req_wdata : 64'd0);
        rd = {$urandom, $urandom};
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        chk_b({tag, "_ls_resp"}, ls_resp_valid, exp_ls);
        chk_b({tag, "_if_resp"}, if_resp_valid, !exp_ls);
        chk_w({tag, "_rdata"}, resp_rdata, rd);
        last_rdata = rd;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_rw = 1'b0; ls_req_addr = '0; ls_req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        last_rdata = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Single LS read, ack in cycle 5.
        ls_req_valid = 1'b1; ls_req_rw = 1'b0; ls_req_addr = 64'h1000;
        tick();
        chk_b("t1_ls_ready", ls_req_ready, 1'b1);
        chk_b("t1_if_ready", if_req_ready, 1'b0);
        chk_b("t1_mem_valid_c1", mem_valid, 1'b1);
        chk_w("t1_mem_addr", mem_addr, 64'h1000);
        chk_b("t1_mem_rw", mem_rw, 1'b0);
        chk_w("t1_state_busy", 64'(fsm_state), 64'd1);
        ls_req_valid = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk_b("t1_mem_valid_hold", mem_valid, 1'b1);
            chk_b("t1_ls_ready_once", ls_req_ready, 1'b0);
            chk_b("t1_no_resp_early", ls_resp_valid, 1'b0);
        end
        tick();
        chk_b("t1_mem_valid_c5", mem_valid, 1'b1);
        mem_ack = 1'b1; mem_rdata = 64'hDEAD;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk_b("t1_ls_resp_c6", ls_resp_valid, 1'b1);
        chk_b("t1_if_resp_c6", if_resp_valid, 1'b0);
        chk_w("t1_rdata", resp_rdata, 64'hDEAD);
        chk_b("t1_err", resp_err, 1'b0);
        chk_b("t1_mem_valid_c6", mem_valid, 1'b0);
        chk_w("t1_state_resp", 64'(fsm_state), 64'd2);
        tick();
        chk_b("t1_ls_resp_c7", ls_resp_valid, 1'b0);
        chk_w("t1_state_idle", 64'(fsm_state), 64'd0);

        // Both held continuously: LS x4 then IF, twice. LS carries a write so the
        // IF grant must force mem_rw=0 and mem_wdata=0.
        if_req_addr = 64'h400; ls_req_addr = 64'h800; ls_req_rw = 1'b1; ls_req_wdata = 64'h77;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        for (int i = 0; i < 10; i++)
            txn($sformatf("t2_g%0d", i), (i % 5) != 4);
        if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_rw = 1'b0;

        // Streak clears when LS wins with no IF waiting.
        for (int i = 0; i < 3; i++) begin
            if_req_valid = 1'b1; ls_req_valid = 1'b1;
            txn($sformatf("t2b_pre%0d", i), 1'b1);
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b1;
        txn("t2b_ls_alone", 1'b1);
        for (int i = 0; i < 5; i++) begin
            if_req_valid = 1'b1; ls_req_valid = 1'b1;
            txn($sformatf("t2b_post%0d", i), i != 4);
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;

        // LS write; inputs wiggle after acceptance, mem_* must stay put.
        ls_req_valid = 1'b1; ls_req_rw = 1'b1; ls_req_addr = 64'h20; ls_req_wdata = 64'h55;
        tick();
        chk_b("t3_ls_ready", ls_req_ready, 1'b1);
        ls_req_valid = 1'b0; ls_req_rw = 1'b0; ls_req_addr = 64'hFFFF; ls_req_wdata = 64'hAAAA;
        if_req_valid = 1'b1; if_req_addr = 64'h999;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            chk_b("t3_mem_rw", mem_rw, 1'b1);
            chk_w("t3_mem_addr", mem_addr, 64'h20);
            chk_w("t3_mem_wdata", mem_wdata, 64'h55);
            chk_b("t3_mem_valid", mem_valid, 1'b1);
        end
        chk_b("t3_if_not_accepted", if_req_ready, 1'b0);
        mem_ack = 1'b1; mem_rdata = 64'hBEEF;
        tick();
        mem_ack = 1'b0; if_req_valid = 1'b0;
        chk_b("t3_ls_resp", ls_resp_valid, 1'b1);
        chk_b("t3_if_resp", if_resp_valid, 1'b0);
        chk_b("t3_err", resp_err, 1'b0);
        tick();
        chk_b("t3_ls_resp_once", ls_resp_valid, 1'b0);
        chk_b("t3_no_if_grant", if_req_ready, 1'b0);

        // Timeout: no ack, error response in cycle 17.
        ls_req_valid = 1'b1; ls_req_addr = 64'h3000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            ls_req_valid = 1'b0;
            chk_b($sformatf("t4_mem_valid_c%0d", c), mem_valid, 1'b1);
            chk_b("t4_no_resp_early", ls_resp_valid, 1'b0);
        end
        tick();
        chk_b("t4_ls_resp_c17", ls_resp_valid, 1'b1);
        chk_b("t4_err", resp_err, 1'b1);
        chk_w("t4_rdata_zero", resp_rdata, 64'd0);
        chk_b("t4_mem_valid_c17", mem_valid, 1'b0);
        tick();
        chk_b("t4_ls_resp_c18", ls_resp_valid, 1'b0);
        chk_b("t4_err_hold", resp_err, 1'b1);

        // Ack in the last cycle before timeout: normal response.
        ls_req_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            ls_req_valid = 1'b0;
            chk_b("t4b_mem_valid", mem_valid, 1'b1);
        end
        mem_ack = 1'b1; mem_rdata = 64'hCAFE;
        tick();
        mem_ack = 1'b0;
        chk_b("t4b_ls_resp", ls_resp_valid, 1'b1);
        chk_b("t4b_err", resp_err, 1'b0);
        chk_w("t4b_rdata", resp_rdata, 64'hCAFE);
        tick();

        // Reset in cycle 3 of a BUSY IF transaction.
        if_req_valid = 1'b1; if_req_addr = 64'h40;
        tick();
        chk_b("t5_if_ready", if_req_ready, 1'b1);
        if_req_valid = 1'b0;
        tick();
        tick();
        chk_w("t5_state_busy_c3", 64'(fsm_state), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t5_c4");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_b("t5_no_if_resp", if_resp_valid, 1'b0);
            chk_b("t5_no_mem_valid", mem_valid, 1'b0);
        end
        if_req_valid = 1'b1; if_req_addr = 64'h44;
        txn("t5_after_rst", 1'b0);
        if_req_valid = 1'b0;

        // Spurious ack in IDLE.
        mem_ack = 1'b1; mem_rdata = 64'h5A5A;
        tick();
        tick();
        mem_ack = 1'b0;
        chk_w("t6_idle_state", 64'(fsm_state), 64'd0);
        chk_b("t6_idle_mem_valid", mem_valid, 1'b0);
        chk_b("t6_idle_ls_resp", ls_resp_valid, 1'b0);
        chk_b("t6_idle_if_resp", if_resp_valid, 1'b0);
        chk_w("t6_idle_rdata_hold", resp_rdata, last_rdata);

        // Spurious ack in RESP.
        ls_req_valid = 1'b1; ls_req_addr = 64'h60;
        tick();
        ls_req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 64'h11;
        tick();
        mem_rdata = 64'h22;
        chk_b("t6_resp_ls_resp", ls_resp_valid, 1'b1);
        chk_w("t6_resp_rdata", resp_rdata, 64'h11);
        tick();
        mem_ack = 1'b0;
        chk_w("t6_after_resp_state", 64'(fsm_state), 64'd0);
        chk_b("t6_after_resp_ls_resp", ls_resp_valid, 1'b0);
        chk_w("t6_after_resp_rdata", resp_rdata, 64'h11);
        chk_b("t6_after_resp_mem_valid", mem_valid, 1'b0);
        tick();
        chk_b("t6_no_accept", mem_valid, 1'b0);
        chk_b("t6_no_ls_ready", ls_req_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
